// File: rtl/key_entry_pkg.sv
// Shared key codes and FSM encoding for the keypad register-entry block.
package key_entry_pkg;

  localparam logic [4:0] KEY_CLEAR     = 5'h10;
  localparam logic [4:0] KEY_CONFIRM   = 5'h11;
  localparam logic [4:0] KEY_BACKSPACE = 5'h12;
  localparam logic [4:0] KEY_PIC       = 5'h13;
  localparam logic [4:0] KEY_HDR       = 5'h14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/key_entry_digit_stack.sv
// Digit storage for one keypad entry: push/pop/clear plus the Horner value
// of the stacked digits (most significant digit pushed first).
module digit_stack #(
  parameter int RADIX = 10,
  parameter int NDIG  = 3,
  parameter int VAL_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [3:0]       push_dig,
  output logic [2:0]       dig_cnt,
  output logic [VAL_W-1:0] value
);

  logic [3:0] digs_q [NDIG];
  logic [3:0] digs_d [NDIG];
  logic [2:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] acc;

  always_comb begin
    digs_d = digs_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (push && (cnt_q < 3'(NDIG))) begin
      for (int i = 0; i < NDIG; i++) begin
        if (3'(i) == cnt_q) digs_d[i] = push_dig;
      end
      cnt_d = cnt_q + 3'd1;
    end else if (pop && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 3'd0;
      for (int i = 0; i < NDIG; i++) digs_q[i] <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      digs_q <= digs_d;
    end
  end

  // Slots at or above the count hold stale popped digits and are skipped.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (3'(i) < cnt_q) acc = acc * VAL_W'(RADIX) + VAL_W'(digs_q[i]);
    end
  end

  assign dig_cnt = cnt_q;
  assign value   = acc;

endmodule

// File: rtl/key_entry.sv
// Keypad-driven register entry: collects an address then a data value and
// hands the pair to an SCCB master with a valid/ready write handshake.
module key_entry
  import key_entry_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RADIX  = 10,
  parameter int NDIG   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              conf_en,
  input  logic              key_valid,
  input  logic [4:0]        key_code,
  input  logic              wr_ready,
  output logic              scan,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] entry_val,
  output logic [2:0]        dig_cnt,
  output logic              phase,
  output logic              err,
  output logic              take_pic,
  output logic              hdr_en,
  output logic [1:0]        state
);

  localparam int VAL_W  = 4 * NDIG;
  localparam int CAND_W = VAL_W + 4;
  localparam logic [4:0] RADIX_K = 5'(RADIX);
  localparam logic [2:0] NDIG_K  = 3'(NDIG);

  state_t state_q, state_d;
  logic key_valid_q, key_ev;
  logic phase_q, phase_d;
  logic wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic err_q, err_d;
  logic take_pic_q, take_pic_d;
  logic hdr_en_q, hdr_en_d;
  logic scan_q, scan_d;
  logic push, pop, clr;
  logic [VAL_W-1:0] stack_val;
  logic [2:0] cnt;
  logic [CAND_W-1:0] cand;
  logic over;

  digit_stack #(.RADIX(RADIX), .NDIG(NDIG), .VAL_W(VAL_W)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clr     (clr),
    .push_dig(key_code[3:0]),
    .dig_cnt (cnt),
    .value   (stack_val)
  );

  assign key_ev = key_valid & ~key_valid_q;
  assign cand   = CAND_W'(stack_val) * CAND_W'(RADIX) + CAND_W'(key_code[3:0]);
  // The digit's value must fit the field being entered: address first, then data.
  assign over   = phase_q ? ((cand >> DATA_W) != '0) : ((cand >> ADDR_W) != '0);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;
    take_pic_d = take_pic_q;
    hdr_en_d   = hdr_en_q;
    push       = 1'b0;
    pop        = 1'b0;
    clr        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_ev && (key_code == KEY_PIC)) take_pic_d = ~take_pic_q;
        if (key_ev && (key_code == KEY_HDR)) hdr_en_d = ~hdr_en_q;
        if (conf_en) state_d = ST_ENTRY;
      end
      ST_ENTRY: begin
        if (!conf_en) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
          phase_d = 1'b0;
        end else if (key_ev) begin
          if (key_code < 5'h10) begin
            if ((key_code >= RADIX_K) || (cnt == NDIG_K) || over) err_d = 1'b1;
            else push = 1'b1;
          end else begin
            case (key_code)
              KEY_CLEAR: clr = 1'b1;
              KEY_BACKSPACE: begin
                if (cnt == 3'd0) err_d = 1'b1;
                else pop = 1'b1;
              end
              KEY_CONFIRM: begin
                if (cnt == 3'd0) begin
                  err_d = 1'b1;
                end else if (!phase_q) begin
                  wr_addr_d = ADDR_W'(stack_val);
                  phase_d   = 1'b1;
                  clr       = 1'b1;
                end else begin
                  wr_data_d  = DATA_W'(stack_val);
                  clr        = 1'b1;
                  wr_valid_d = 1'b1;
                  state_d    = ST_ISSUE;
                end
              end
              default: ;
            endcase
          end
        end
      end
      ST_ISSUE: begin
        if (wr_valid_q && wr_ready) begin
          wr_valid_d = 1'b0;
          phase_d    = 1'b0;
          state_d    = conf_en ? ST_ENTRY : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    scan_d = (state_d == ST_ENTRY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      phase_q     <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      take_pic_q  <= 1'b0;
      hdr_en_q    <= 1'b0;
      scan_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid;
      phase_q     <= phase_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      take_pic_q  <= take_pic_d;
      hdr_en_q    <= hdr_en_d;
      scan_q      <= scan_d;
    end
  end

  assign scan      = scan_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign entry_val = DATA_W'(stack_val);
  assign dig_cnt   = cnt;
  assign phase     = phase_q;
  assign err       = err_q;
  assign take_pic  = take_pic_q;
  assign hdr_en    = hdr_en_q;
  assign state     = state_q;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: a default decimal instance plus a hex
// instance sharing the same keypad stimulus; writes are checked via a scoreboard.
module tb_key_entry;
  import key_entry_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic conf_en = 1'b0;
  logic key_valid = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic wr_ready = 1'b0;

  logic scan, wr_valid, phase, err, take_pic, hdr_en;
  logic [7:0] wr_addr, wr_data, entry_val;
  logic [2:0] dig_cnt;
  logic [1:0] state;

  logic h_scan, h_wr_valid, h_phase, h_err, h_take_pic, h_hdr_en;
  logic [7:0] h_wr_addr, h_wr_data, h_entry_val;
  logic [2:0] h_dig_cnt;
  logic [1:0] h_state;

  int total_cnt = 0;
  int pass_cnt = 0;
  int err_cnt = 0;
  int err_base;
  logic [15:0] exp_q[$];

  key_entry dut (
    .clk(clk), .rst(rst), .conf_en(conf_en), .key_valid(key_valid),
    .key_code(key_code), .wr_ready(wr_ready), .scan(scan), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .entry_val(entry_val),
    .dig_cnt(dig_cnt), .phase(phase), .err(err), .take_pic(take_pic),
    .hdr_en(hdr_en), .state(state)
  );

  key_entry #(.RADIX(16), .NDIG(2)) dut_hex (
    .clk(clk), .rst(rst), .conf_en(conf_en), .key_valid(key_valid),
    .key_code(key_code), .wr_ready(wr_ready), .scan(h_scan), .wr_valid(h_wr_valid),
    .wr_addr(h_wr_addr), .wr_data(h_wr_data), .entry_val(h_entry_val),
    .dig_cnt(h_dig_cnt), .phase(h_phase), .err(h_err), .take_pic(h_take_pic),
    .hdr_en(h_hdr_en), .state(h_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [4:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseReady();
    @(negedge clk);
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
  endtask

  // Err pulses of the decimal instance, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (err) err_cnt++;
  end

  // Scoreboard: every completed handshake must match the oldest expected write.
  always @(negedge clk) begin
    #1;
    if (wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_write", 32'(1), 32'(0));
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        checkOutput("sb_write", {16'd0, wr_addr, wr_data}, {16'd0, e});
      end
    end
  end

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("rst_state", 32'(state), 32'(0));
    checkOutput("rst_wr_valid", 32'(wr_valid), 32'(0));
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'(0));
    checkOutput("rst_wr_data", 32'(wr_data), 32'(0));
    checkOutput("rst_dig_cnt", 32'(dig_cnt), 32'(0));
    checkOutput("rst_phase", 32'(phase), 32'(0));
    checkOutput("rst_scan", 32'(scan), 32'(0));
    checkOutput("rst_entry_val", 32'(entry_val), 32'(0));
    checkOutput("rst_take_pic", 32'(take_pic), 32'(0));

    applyStimulus(KEY_PIC);
    checkOutput("pic_toggle_on", 32'(take_pic), 32'(1));
    applyStimulus(KEY_PIC);
    checkOutput("pic_toggle_off", 32'(take_pic), 32'(0));
    applyStimulus(KEY_HDR);
    checkOutput("hdr_toggle_on", 32'(hdr_en), 32'(1));
    applyStimulus(5'd5);
    checkOutput("idle_digit_ignored", 32'(dig_cnt), 32'(0));

    conf_en = 1'b1;
    tick(2);
    checkOutput("enter_state", 32'(state), 32'(1));
    checkOutput("enter_scan", 32'(scan), 32'(1));

    applyStimulus(5'd1);
    applyStimulus(5'd2);
    applyStimulus(5'd3);
    checkOutput("entry_123", 32'(entry_val), 32'(123));
    applyStimulus(KEY_CONFIRM);
    checkOutput("addr_phase", 32'(phase), 32'(1));
    checkOutput("addr_stack_empty", 32'(dig_cnt), 32'(0));
    applyStimulus(5'd0);
    applyStimulus(5'd5);
    applyStimulus(5'd5);
    exp_q.push_back({8'h7B, 8'h37});
    applyStimulus(KEY_CONFIRM);
    checkOutput("issue_state", 32'(state), 32'(2));
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_wr_valid", 32'(wr_valid), 32'(1));
      checkOutput("hold_wr_addr", 32'(wr_addr), 32'h7B);
      checkOutput("hold_wr_data", 32'(wr_data), 32'h37);
      tick(1);
    end
    pulseReady();
    checkOutput("hs_wr_valid_drop", 32'(wr_valid), 32'(0));
    checkOutput("hs_phase_zero", 32'(phase), 32'(0));
    checkOutput("hs_back_to_entry", 32'(state), 32'(1));

    err_base = err_cnt;
    applyStimulus(5'd2);
    applyStimulus(5'd5);
    applyStimulus(5'd6);
    checkOutput("range_entry_25", 32'(entry_val), 32'(25));
    checkOutput("range_err_once", 32'(err_cnt - err_base), 32'(1));
    applyStimulus(KEY_CLEAR);
    checkOutput("clear_empty", 32'(dig_cnt), 32'(0));
    applyStimulus(5'd1);
    applyStimulus(5'd0);
    applyStimulus(5'd0);
    applyStimulus(5'd1);
    checkOutput("full_entry_100", 32'(entry_val), 32'(100));
    checkOutput("full_err", 32'(err_cnt - err_base), 32'(2));

    applyStimulus(KEY_CLEAR);
    applyStimulus(5'd4);
    applyStimulus(5'd7);
    applyStimulus(KEY_BACKSPACE);
    applyStimulus(5'd9);
    checkOutput("bksp_entry_49", 32'(entry_val), 32'(49));
    checkOutput("bksp_dig_cnt", 32'(dig_cnt), 32'(2));
    applyStimulus(KEY_CLEAR);
    err_base = err_cnt;
    applyStimulus(KEY_BACKSPACE);
    checkOutput("bksp_empty_err", 32'(err_cnt - err_base), 32'(1));
    applyStimulus(KEY_CONFIRM);
    checkOutput("confirm_empty_err", 32'(err_cnt - err_base), 32'(2));
    checkOutput("confirm_empty_phase", 32'(phase), 32'(0));

    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 5'd3;
    tick(10);
    key_valid = 1'b0;
    tick(1);
    checkOutput("held_key_one_digit", 32'(dig_cnt), 32'(1));
    applyStimulus(KEY_CONFIRM);
    applyStimulus(5'd1);
    applyStimulus(5'd2);
    checkOutput("abort_pre_cnt", 32'(dig_cnt), 32'(2));
    checkOutput("abort_pre_phase", 32'(phase), 32'(1));
    conf_en = 1'b0;
    tick(2);
    checkOutput("abort_state_idle", 32'(state), 32'(0));
    checkOutput("abort_dig_cnt", 32'(dig_cnt), 32'(0));
    checkOutput("abort_phase", 32'(phase), 32'(0));
    checkOutput("abort_scan", 32'(scan), 32'(0));

    conf_en = 1'b1;
    tick(2);
    @(negedge clk);
    conf_en   = 1'b0;
    key_valid = 1'b1;
    key_code  = 5'd4;
    @(negedge clk);
    key_valid = 1'b0;
    conf_en   = 1'b1;
    tick(2);
    checkOutput("exit_drops_key", 32'(dig_cnt), 32'(0));

    applyStimulus(5'd9);
    applyStimulus(KEY_CONFIRM);
    applyStimulus(5'd8);
    exp_q.push_back({8'h09, 8'h08});
    applyStimulus(KEY_CONFIRM);
    conf_en = 1'b0;
    tick(3);
    checkOutput("issue_survives_conf", 32'(state), 32'(2));
    checkOutput("issue_valid_held", 32'(wr_valid), 32'(1));
    applyStimulus(5'd1);
    checkOutput("issue_key_ignored", 32'(dig_cnt), 32'(0));
    pulseReady();
    checkOutput("issue_to_idle", 32'(state), 32'(0));
    checkOutput("issue_done_valid", 32'(wr_valid), 32'(0));

    conf_en = 1'b1;
    tick(2);
    applyStimulus(5'd1);
    applyStimulus(KEY_CONFIRM);
    applyStimulus(5'd2);
    applyStimulus(KEY_CONFIRM);
    checkOutput("rst_issue_pre", 32'(wr_valid), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_issue_valid", 32'(wr_valid), 32'(0));
    checkOutput("rst_issue_state", 32'(state), 32'(0));

    conf_en = 1'b0;
    tick(2);
    rst = 1'b0;
    conf_en = 1'b1;
    tick(2);
    err_base = err_cnt;
    applyStimulus(5'h0A);
    applyStimulus(5'h0F);
    applyStimulus(KEY_CONFIRM);
    checkOutput("hex_wr_addr", 32'(h_wr_addr), 32'hAF);
    checkOutput("hex_phase", 32'(h_phase), 32'(1));
    checkOutput("dec_hex_keys_err", 32'(err_cnt - err_base), 32'(3));
    applyStimulus(5'd7);
    applyStimulus(5'h0B);
    checkOutput("dec_b_entry_kept", 32'(entry_val), 32'(7));
    checkOutput("dec_b_dig_cnt", 32'(dig_cnt), 32'(1));
    checkOutput("dec_b_err", 32'(err_cnt - err_base), 32'(4));
    checkOutput("hex_entry_7b", 32'(h_entry_val), 32'h7B);

    tick(2);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, register data width; ADDR_W, default 8, register address width; RADIX, default 10, entry base (10 or 16 only); NDIG, default 3, maximum digits per entry (1..6).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: conf_en  in  1  level, enables register-entry mode.
REQ-005 SHALL have ports: key_valid  in  1  level from keypad scanner, high while key_code is valid.
REQ-006 SHALL have ports: key_code  in  5  key code: 0x00-0x0F value, 0x10 CLEAR, 0x11 CONFIRM, 0x12 BACKSPACE, 0x13 PIC, 0x14 HDR; others ignored.
REQ-007 SHALL have ports: wr_ready  in  1  downstream SCCB master accepts write.
REQ-008 SHALL have ports: scan  out  1; wr_valid  out  1; wr_addr  out  ADDR_W; wr_data  out  DATA_W; entry_val  out  DATA_W (current entry, for display); dig_cnt  out  3; phase  out  1 (0 = address, 1 = data); err  out  1 (one-cycle pulse); take_pic  out  1; hdr_en  out  1; state  out  2.

Function
REQ-009 SHALL act only on key events: a key event is a rising edge of key_valid, detected by one register stage, so a held key yields exactly one event.
REQ-010 SHALL implement states IDLE (0), ENTRY (1), ISSUE (2); scan SHALL be 1 only in ENTRY.
REQ-011 In IDLE: PIC event SHALL toggle take_pic and HDR event SHALL toggle hdr_en; all other keys SHALL be ignored; conf_en=1 SHALL move to ENTRY the next cycle.
REQ-012 In ENTRY: a value key SHALL be a digit only if it is < RADIX; otherwise err SHALL pulse and the entry SHALL be unchanged.
REQ-013 Digits SHALL be held in an NDIG-deep digit stack; entry_val SHALL equal the Horner value of the stacked digits, zero when empty.
REQ-014 A digit SHALL be rejected with an err pulse if dig_cnt == NDIG, or if the new value exceeds 2^ADDR_W-1 (phase 0) or 2^DATA_W-1 (phase 1).
REQ-015 BACKSPACE SHALL pop the last digit; on an empty stack it SHALL pulse err.
REQ-016 CLEAR SHALL empty the stack and keep phase.
REQ-017 CONFIRM with dig_cnt == 0 SHALL pulse err with no other effect.
REQ-018 CONFIRM in phase 0 SHALL latch wr_addr <= entry_val, set phase=1 and empty the stack.
REQ-019 CONFIRM in phase 1 SHALL latch wr_data <= entry_val, empty the stack, assert wr_valid and enter ISSUE.
REQ-020 In ISSUE: wr_valid, wr_addr and wr_data SHALL remain stable until a cycle with wr_valid & wr_ready; in that cycle wr_valid SHALL drop on the next edge and phase SHALL become 0.
REQ-021 After the handshake, ISSUE SHALL go to ENTRY if conf_en=1, else to IDLE; key events in ISSUE SHALL be ignored.
REQ-022 conf_en=0 in ENTRY SHALL go to IDLE, empty the stack and set phase=0; conf_en=0 in ISSUE SHALL NOT abort the transaction.
REQ-023 If a key event and conf_en falling coincide in ENTRY, the conf_en exit SHALL take priority and the key SHALL be dropped.
REQ-024 All outputs SHALL be registered except entry_val, which SHALL be combinational from the digit stack.

Reset
REQ-025 rst SHALL set state=IDLE, stack empty, dig_cnt=0, phase=0, wr_valid=0, wr_addr=0, wr_data=0, err=0, take_pic=0, hdr_en=0, scan=0, and clear the key_valid edge register.
REQ-026 rst asserted in ISSUE SHALL drop wr_valid on the next edge without a handshake.

Structure
REQ-027 Package key_entry_pkg SHALL hold the key code constants (KEY_CLEAR, KEY_CONFIRM, KEY_BACKSPACE, KEY_PIC, KEY_HDR) and the state encoding.
REQ-028 Sub-module digit_stack SHALL hold the push/pop/clear digit storage, dig_cnt and the Horner value; key_entry SHALL hold the FSM, range checks and handshake.

Verification
REQ-029 Defaults: keys 1,2,3,CONFIRM then 0,5,5,CONFIRM with wr_ready=0 for 5 cycles -> wr_valid held 5 cycles with wr_addr=0x7B and wr_data=0x37, one handshake, then phase=0.
REQ-030 Defaults: keys 2,5,6 -> third digit rejected, err pulses once, entry_val=25; a fourth digit after 1,0,0 -> err.
REQ-031 Defaults: keys 4,7,BACKSPACE,9 -> entry_val=49, dig_cnt=2; BACKSPACE on an empty stack -> err.
REQ-032 key_valid held 10 cycles with code 0x03 -> one digit; conf_en dropped with dig_cnt=2 in phase 1 -> IDLE, dig_cnt=0, phase=0.
REQ-033 RADIX=16, NDIG=2: keys 0x0A,0x0F,CONFIRM -> wr_addr=0xAF; RADIX=10: key 0x0B -> err, entry unchanged.
REQ-034 IDLE: PIC event twice -> take_pic 0->1->0; conf_en dropped in ISSUE -> transaction completes, then IDLE.
